// File: rtl/ddr3_cmd_lane_ctrl.sv
// Address/command lane controller: registers 4-beat command data toward the IOD lanes
// and sequences LOAD/MOVE delay-line adjustments on one selected lane while tracking taps.
module ddr3_cmd_lane_ctrl #(
  parameter int   NUM_LANES = 3,
  parameter int   TAP_W     = 8,
  parameter int   MAX_TAP   = 255,
  parameter int   STEP_W    = 6,
  parameter int   MOVE_GAP  = 4,
  parameter logic IDLE_VAL  = 1'b0,
  localparam int  LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       FAB_CLK,
  input  logic                       ARST_N,
  input  logic                       CMD_VALID,
  input  logic [4*NUM_LANES-1:0]     CMD_DATA,
  input  logic                       CMD_OE,
  input  logic                       CMD_ODT,
  output logic [4*NUM_LANES-1:0]     TX_DATA,
  output logic [4*NUM_LANES-1:0]     OE_DATA,
  output logic [NUM_LANES-1:0]       ODT_EN,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  input  logic                       ADJ_REQ,
  input  logic [LANE_W-1:0]          ADJ_LANE,
  input  logic                       ADJ_LOAD,
  input  logic                       ADJ_DIR,
  input  logic [STEP_W-1:0]          ADJ_STEPS,
  output logic                       ADJ_BUSY,
  output logic                       ADJ_DONE,
  output logic                       ADJ_ERR,
  output logic [TAP_W*NUM_LANES-1:0] TAP_VALUE,
  output logic [2:0]                 ADJ_STATE
);

  localparam int GAP_W = (MOVE_GAP > 0) ? $clog2(MOVE_GAP + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_LOAD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state;
  logic [LANE_W-1:0]  lane_q;
  logic               load_q;
  logic               dir_q;
  logic [STEP_W-1:0]  steps_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TAP_W-1:0]   tap_q [NUM_LANES];

  logic [NUM_LANES-1:0] lane_oh;
  logic [TAP_W-1:0]     cur_tap;
  logic                 lane_ok;
  logic                 at_limit;
  logic                 oor_hit;

  always_comb begin
    lane_oh = '0;
    cur_tap = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (int'(lane_q) == k) begin
        lane_oh[k] = 1'b1;
        cur_tap    = tap_q[k];
      end
    end
    lane_ok  = (int'(lane_q) < NUM_LANES);
    // A further step in the latched direction would leave the legal tap range.
    at_limit = dir_q ? (cur_tap == TAP_W'(MAX_TAP)) : (cur_tap == '0);
    oor_hit  = |(DELAY_LINE_OUT_OF_RANGE & lane_oh);
  end

  always_comb begin
    TAP_VALUE = '0;
    for (int k = 0; k < NUM_LANES; k++) TAP_VALUE[k*TAP_W +: TAP_W] = tap_q[k];
  end

  assign ADJ_STATE = state;

  // Handshake: ADJ_REQ is taken only in IDLE (ADJ_BUSY=0, ADJ_DONE=0) and ADJ_* are
  // captured on that edge; ADJ_BUSY stays high until the single-cycle ADJ_DONE, which
  // carries ADJ_ERR. Requests seen while busy or in the done cycle are dropped.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                <= S_IDLE;
      lane_q               <= '0;
      load_q               <= 1'b0;
      dir_q                <= 1'b0;
      steps_q              <= '0;
      gap_cnt              <= '0;
      TX_DATA              <= '0;
      OE_DATA              <= '0;
      ODT_EN               <= '0;
      DELAY_LINE_MOVE      <= '0;
      DELAY_LINE_DIRECTION <= '0;
      DELAY_LINE_LOAD      <= '0;
      ADJ_BUSY             <= 1'b0;
      ADJ_DONE             <= 1'b0;
      ADJ_ERR              <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) tap_q[k] <= '0;
    end else begin
      TX_DATA         <= CMD_VALID ? CMD_DATA : {4*NUM_LANES{IDLE_VAL}};
      OE_DATA         <= {4*NUM_LANES{CMD_OE}};
      ODT_EN          <= {NUM_LANES{CMD_ODT}};
      DELAY_LINE_MOVE <= '0;
      DELAY_LINE_LOAD <= '0;
      ADJ_DONE        <= 1'b0;
      ADJ_ERR         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (ADJ_REQ) begin
            state    <= S_SETUP;
            lane_q   <= ADJ_LANE;
            load_q   <= ADJ_LOAD;
            dir_q    <= ADJ_DIR;
            steps_q  <= ADJ_STEPS;
            ADJ_BUSY <= 1'b1;
            for (int k = 0; k < NUM_LANES; k++)
              DELAY_LINE_DIRECTION[k] <= ADJ_DIR && (int'(ADJ_LANE) == k);
          end
        end

        S_SETUP: begin
          if (!lane_ok || (!load_q && steps_q != '0 && at_limit)) begin
            state                <= S_DONE;
            ADJ_DONE             <= 1'b1;
            ADJ_ERR              <= 1'b1;
            ADJ_BUSY             <= 1'b0;
            DELAY_LINE_DIRECTION <= '0;
          end else if (load_q) begin
            state           <= S_LOAD;
            DELAY_LINE_LOAD <= lane_oh;
            gap_cnt         <= GAP_W'(MOVE_GAP);
            for (int k = 0; k < NUM_LANES; k++)
              if (lane_oh[k]) tap_q[k] <= '0;
          end else if (steps_q == '0) begin
            state                <= S_DONE;
            ADJ_DONE             <= 1'b1;
            ADJ_BUSY             <= 1'b0;
            DELAY_LINE_DIRECTION <= '0;
          end else begin
            state           <= S_PULSE;
            DELAY_LINE_MOVE <= lane_oh;
            steps_q         <= steps_q - STEP_W'(1);
            for (int k = 0; k < NUM_LANES; k++)
              if (lane_oh[k]) tap_q[k] <= dir_q ? tap_q[k] + TAP_W'(1) : tap_q[k] - TAP_W'(1);
          end
        end

        S_PULSE: begin
          state   <= S_GAP;
          gap_cnt <= GAP_W'(MOVE_GAP - 1);
        end

        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (oor_hit || steps_q == '0 || at_limit) begin
            state                <= S_DONE;
            ADJ_DONE             <= 1'b1;
            ADJ_ERR              <= oor_hit || (steps_q != '0);
            ADJ_BUSY             <= 1'b0;
            DELAY_LINE_DIRECTION <= '0;
          end else begin
            state           <= S_PULSE;
            DELAY_LINE_MOVE <= lane_oh;
            steps_q         <= steps_q - STEP_W'(1);
            for (int k = 0; k < NUM_LANES; k++)
              if (lane_oh[k]) tap_q[k] <= dir_q ? tap_q[k] + TAP_W'(1) : tap_q[k] - TAP_W'(1);
          end
        end

        S_LOAD: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else begin
            state                <= S_DONE;
            ADJ_DONE             <= 1'b1;
            ADJ_BUSY             <= 1'b0;
            DELAY_LINE_DIRECTION <= '0;
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_lane_ctrl.sv
// Randomized bench for ddr3_cmd_lane_ctrl: a reference model predicts each adjust outcome
// and the datapath word; a monitor pops and compares whenever the DUT presents a result.
module tb_ddr3_cmd_lane_ctrl;
  localparam int   NL   = 3;
  localparam int   TW   = 8;
  localparam int   MAXT = 255;
  localparam int   SW   = 6;
  localparam int   G    = 4;
  localparam int   LW   = 2;
  localparam int   DW   = 4 * NL;
  localparam logic IDLE = 1'b0;

  logic             FAB_CLK = 1'b0;
  logic             ARST_N  = 1'b0;
  logic             CMD_VALID = 1'b0;
  logic [DW-1:0]    CMD_DATA  = '0;
  logic             CMD_OE    = 1'b0;
  logic             CMD_ODT   = 1'b0;
  logic [DW-1:0]    TX_DATA, OE_DATA;
  logic [NL-1:0]    ODT_EN, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
  logic [NL-1:0]    DELAY_LINE_OUT_OF_RANGE;
  logic             ADJ_REQ = 1'b0, ADJ_LOAD = 1'b0, ADJ_DIR = 1'b0;
  logic [LW-1:0]    ADJ_LANE = '0;
  logic [SW-1:0]    ADJ_STEPS = '0;
  logic             ADJ_BUSY, ADJ_DONE, ADJ_ERR;
  logic [TW*NL-1:0] TAP_VALUE;
  logic [2:0]       ADJ_STATE;

  ddr3_cmd_lane_ctrl #(
    .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(MAXT), .STEP_W(SW), .MOVE_GAP(G), .IDLE_VAL(IDLE)
  ) dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
    .CMD_VALID(CMD_VALID), .CMD_DATA(CMD_DATA), .CMD_OE(CMD_OE), .CMD_ODT(CMD_ODT),
    .TX_DATA(TX_DATA), .OE_DATA(OE_DATA), .ODT_EN(ODT_EN),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .ADJ_REQ(ADJ_REQ), .ADJ_LANE(ADJ_LANE), .ADJ_LOAD(ADJ_LOAD), .ADJ_DIR(ADJ_DIR),
    .ADJ_STEPS(ADJ_STEPS), .ADJ_BUSY(ADJ_BUSY), .ADJ_DONE(ADJ_DONE), .ADJ_ERR(ADJ_ERR),
    .TAP_VALUE(TAP_VALUE), .ADJ_STATE(ADJ_STATE)
  );

  // ---------------- clock ----------------
  always #5 FAB_CLK = ~FAB_CLK;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0]      done_cyc;
    logic             err;
    logic [6:0]       pulses;
    logic             loads;
    logic [TW*NL-1:0] taps;
  } adj_exp_t;

  adj_exp_t          adj_q[$];
  logic [DW+DW+NL-1:0] exp_q[$];

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            sim_done = 1'b0;
  int            cur_lane = -1;
  logic          cur_dir = 1'b0;
  int            cur_oor_k = 0;
  int            mv_cnt = 0;
  int            ld_cnt = 0;
  logic [NL-1:0] oor_drive = '0;
  int            tb_tap[NL];

  assign DELAY_LINE_OUT_OF_RANGE = oor_drive;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NL-1:0] onehot(input int lane);
    logic [NL-1:0] v;
    v = '0;
    if (lane >= 0 && lane < NL) v[lane] = 1'b1;
    return v;
  endfunction

  function automatic logic [TW*NL-1:0] taps_vec();
    logic [TW*NL-1:0] v;
    v = '0;
    for (int k = 0; k < NL; k++) v[k*TW +: TW] = TW'(tb_tap[k]);
    return v;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({TX_DATA, OE_DATA, ODT_EN, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                DELAY_LINE_LOAD, ADJ_BUSY, ADJ_DONE, ADJ_ERR, TAP_VALUE});
  endfunction

  // Reference model: outcome of one request from the tap-range rules alone.
  // done_cyc holds the latency (REQ cycle to DONE cycle) until the caller rebases it.
  function automatic adj_exp_t model(input int lane, input bit load, input bit dir,
                                     input int steps, input int oor_k);
    adj_exp_t e;
    int room, lim, n, lat;
    e = '0;
    n = 0;
    if (lane >= NL) begin
      e.err = 1'b1;
      lat   = 2;
    end else if (load) begin
      e.loads      = 1'b1;
      tb_tap[lane] = 0;
      lat          = 3 + G;
    end else if (steps == 0) begin
      lat = 2;
    end else begin
      room = dir ? (MAXT - tb_tap[lane]) : tb_tap[lane];
      lim  = (steps < room) ? steps : room;
      if (oor_k > 0 && oor_k <= lim) begin
        n     = oor_k;
        e.err = 1'b1;
      end else begin
        n     = lim;
        e.err = (room < steps);
      end
      tb_tap[lane] = dir ? tb_tap[lane] + n : tb_tap[lane] - n;
      lat = 2 + n * (1 + G);
    end
    e.pulses   = 7'(n);
    e.done_cyc = 32'(lat);
    e.taps     = taps_vec();
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [DW+DW+NL-1:0] dexp;
    adj_exp_t e;
    forever begin
      @(posedge FAB_CLK);
      cyc++;
      #1;
      if (!ARST_N) begin
        mv_cnt    = 0;
        ld_cnt    = 0;
        oor_drive = '0;
      end else begin
        if (exp_q.size() > 0) begin
          dexp = exp_q.pop_front();
          chk("datapath", 64'({TX_DATA, OE_DATA, ODT_EN}), 64'(dexp));
        end
        if (DELAY_LINE_MOVE != '0) begin
          chk("move_lane", 64'(DELAY_LINE_MOVE), 64'(onehot(cur_lane)));
          mv_cnt++;
          if (cur_oor_k > 0 && mv_cnt >= cur_oor_k) oor_drive = onehot(cur_lane);
        end
        if (DELAY_LINE_LOAD != '0) begin
          chk("load_lane", 64'(DELAY_LINE_LOAD), 64'(onehot(cur_lane)));
          ld_cnt++;
        end
        chk("direction", 64'(DELAY_LINE_DIRECTION),
            64'((ADJ_BUSY && cur_dir) ? onehot(cur_lane) : '0));
        if (ADJ_DONE) begin
          if (adj_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: ADJ_DONE=1 at cycle %0d, expected no completion", cyc);
          end else begin
            e = adj_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
            chk("adj_err", 64'(ADJ_ERR), 64'(e.err));
            chk("tap_value", 64'(TAP_VALUE), 64'(e.taps));
            chk("move_count", 64'(mv_cnt), 64'(e.pulses));
            chk("load_count", 64'(ld_cnt), 64'(e.loads));
          end
          mv_cnt    = 0;
          ld_cnt    = 0;
          oor_drive = '0;
          cur_lane  = -1;
          cur_dir   = 1'b0;
          cur_oor_k = 0;
        end
      end
    end
  end

  // ---------------- datapath driver ----------------
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge FAB_CLK);
      if (sim_done) break;
      if (k < 3) begin
        CMD_VALID = 1'b0;
        CMD_DATA  = DW'($urandom);
      end else if (k == 3) begin
        CMD_VALID = 1'b1;
        CMD_DATA  = 12'hA5C;
      end else begin
        CMD_VALID = 1'($urandom_range(0, 1));
        CMD_DATA  = DW'($urandom);
      end
      CMD_OE  = 1'($urandom_range(0, 1));
      CMD_ODT = 1'($urandom_range(0, 1));
      if (ARST_N) begin
        exp_q.push_back({CMD_VALID ? CMD_DATA : {DW{IDLE}}, {DW{CMD_OE}}, {NL{CMD_ODT}}});
        k++;
      end
    end
  end

  // ---------------- adjust driver ----------------
  task automatic run_adj(input int lane, input bit load, input bit dir, input int steps,
                         input int oor_k, input bit spur);
    adj_exp_t e;
    int waited, lat;
    waited = 0;
    while ((ADJ_BUSY || ADJ_DONE) && waited < 400) begin
      @(negedge FAB_CLK);
      waited++;
    end
    chk("idle_before_req", 64'(ADJ_BUSY || ADJ_DONE), 64'(0));
    e          = model(lane, load, dir, steps, oor_k);
    lat        = int'(e.done_cyc);
    e.done_cyc = 32'(cyc + lat);
    cur_lane   = lane;
    cur_dir    = dir;
    cur_oor_k  = oor_k;
    adj_q.push_back(e);
    ADJ_REQ   = 1'b1;
    ADJ_LANE  = LW'(lane);
    ADJ_LOAD  = load;
    ADJ_DIR   = dir;
    ADJ_STEPS = SW'(steps);
    @(negedge FAB_CLK);
    ADJ_REQ   = 1'b0;
    ADJ_LANE  = LW'($urandom);
    ADJ_LOAD  = 1'($urandom_range(0, 1));
    ADJ_DIR   = 1'($urandom_range(0, 1));
    ADJ_STEPS = SW'($urandom);
    waited = 0;
    while (adj_q.size() != 0 && waited < lat + 20) begin
      ADJ_REQ = spur && ADJ_BUSY && ($urandom_range(0, 1) == 1);
      @(negedge FAB_CLK);
      waited++;
    end
    ADJ_REQ = 1'b0;
    chk("done_seen", 64'(adj_q.size()), 64'(0));
    if (adj_q.size() != 0) begin
      adj_q.delete();
      cur_lane  = -1;
      cur_dir   = 1'b0;
      cur_oor_k = 0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lane, steps, oor_k;
    bit load, dir, spur;
    for (int k = 0; k < NL; k++) tb_tap[k] = 0;

    repeat (3) @(negedge FAB_CLK);
    chk("reset_outputs", all_outs(), 64'(0));
    #2 ARST_N = 1'b1;
    repeat (8) @(negedge FAB_CLK);

    run_adj(1, 1'b0, 1'b1, 3, 0, 1'b0);
    run_adj(0, 1'b0, 1'b0, 1, 0, 1'b0);
    run_adj(2, 1'b0, 1'b1, 5, 2, 1'b0);
    run_adj(1, 1'b1, 1'b0, 7, 0, 1'b1);
    run_adj(3, 1'b0, 1'b1, 4, 0, 1'b0);
    run_adj(2, 1'b0, 1'b0, 0, 0, 1'b0);

    // Abort a move sequence part-way through its gap with the async reset.
    while (ADJ_BUSY || ADJ_DONE) @(negedge FAB_CLK);
    cur_lane  = 0;
    cur_dir   = 1'b1;
    cur_oor_k = 0;
    ADJ_REQ   = 1'b1;
    ADJ_LANE  = 2'd0;
    ADJ_LOAD  = 1'b0;
    ADJ_DIR   = 1'b1;
    ADJ_STEPS = SW'(10);
    @(negedge FAB_CLK);
    ADJ_REQ = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    #2 ARST_N = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NL; k++) tb_tap[k] = 0;
    cur_lane = -1;
    cur_dir  = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 64'(0));
    repeat (2) @(negedge FAB_CLK);
    #2 ARST_N = 1'b1;
    repeat (12) @(negedge FAB_CLK);
    chk("tap_after_reset", 64'(TAP_VALUE), 64'(0));
    run_adj(0, 1'b0, 1'b1, 2, 0, 1'b1);

    // Drive lane 1 up to the top of the tap range.
    repeat (4) run_adj(1, 1'b0, 1'b1, 63, 0, 1'b0);
    run_adj(1, 1'b0, 1'b1, 5, 0, 1'b0);
    run_adj(1, 1'b0, 1'b1, 1, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      lane  = int'($urandom_range(0, 3));
      load  = ($urandom_range(0, 7) == 0);
      dir   = ($urandom_range(0, 3) != 0);
      steps = int'($urandom_range(0, 20));
      oor_k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, (steps > 0) ? steps : 1)) : 0;
      spur  = 1'($urandom_range(0, 1));
      run_adj(lane, load, dir, steps, oor_k, spur);
    end

    sim_done = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
